// File: rtl/regfile_param.sv
// Parametrised register file for the Beta datapath.
//
// Two combinational read ports (a, b) and one synchronous write port (d/w_sel/w_en).
// Register DEPTH-1 is hardwired to zero. An optional write-to-read bypass forwards `d` to a
// read port that selects the register being written in the same cycle.
// A clear sequencer zeroes registers 0..DEPTH-2, one per cycle, after reset or when `clr`
// is pulsed. `busy` is high while it runs; reads return 0 and writes/clr are dropped.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset (starts a clear sweep)
//   d      write data
//   w_sel  write register index
//   w_en   write enable
//   a_sel  read port A index
//   b_sel  read port B index
//   clr    single-cycle request to re-run the clear sweep
//   a      read port A data
//   b      read port B data
//   busy   clear sweep in progress
module regfile_param #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BYPASS = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  d,
    input  logic [ADDR_W-1:0] w_sel,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] a_sel,
    input  logic [ADDR_W-1:0] b_sel,
    input  logic              clr,
    output logic [WIDTH-1:0]  a,
    output logic [WIDTH-1:0]  b,
    output logic              busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 2);

    typedef enum logic {
        StIdle,
        StClear
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    // Only the writable registers are stored; the zero register has no storage.
    logic [WIDTH-1:0]  mem_q [DEPTH-1];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    assign busy = (state_q == StClear);

    // Sequencer next state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StClear: begin
                if (idx_q == LAST_IDX) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StIdle: begin
                if (clr) begin
                    state_d = StClear;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StClear;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // The sweep owns the write port while busy; user writes are discarded then.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = w_sel;
        wr_data = d;
        if (state_q == StClear) begin
            wr_en   = 1'b1;
            wr_addr = idx_q;
            wr_data = '0;
        end else if (w_en && (w_sel != ZERO_IDX)) begin
            wr_en = 1'b1;
        end
    end

    // Storage is deliberately not reset; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read ports. A select equal to ZERO_IDX never indexes storage.
    always_comb begin
        a = '0;
        if (!busy && (a_sel != ZERO_IDX)) begin
            if ((BYPASS != 0) && w_en && (w_sel == a_sel)) begin
                a = d;
            end else begin
                a = mem_q[a_sel];
            end
        end
    end

    always_comb begin
        b = '0;
        if (!busy && (b_sel != ZERO_IDX)) begin
            if ((BYPASS != 0) && w_en && (w_sel == b_sel)) begin
                b = d;
            end else begin
                b = mem_q[b_sel];
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

    logic        clk;
    logic        reset;
    logic [31:0] d;
    logic [4:0]  w_sel;
    logic        w_en;
    logic [4:0]  a_sel;
    logic [4:0]  b_sel;
    logic        clr;
    logic [31:0] a0, b0, a1, b1;
    logic        busy0, busy1;

    logic        reset2;
    logic [7:0]  d2;
    logic [2:0]  w_sel2, a_sel2, b_sel2;
    logic        w_en2, clr2;
    logic [7:0]  a2, b2;
    logic        busy2;

    int pass_cnt = 0;
    int total_cnt = 0;

    regfile_param #(.WIDTH(32), .ADDR_W(5), .BYPASS(0)) dut0 (
        .clk(clk), .reset(reset), .d(d), .w_sel(w_sel), .w_en(w_en),
        .a_sel(a_sel), .b_sel(b_sel), .clr(clr), .a(a0), .b(b0), .busy(busy0)
    );

    regfile_param #(.WIDTH(32), .ADDR_W(5), .BYPASS(1)) dut1 (
        .clk(clk), .reset(reset), .d(d), .w_sel(w_sel), .w_en(w_en),
        .a_sel(a_sel), .b_sel(b_sel), .clr(clr), .a(a1), .b(b1), .busy(busy1)
    );

    regfile_param #(.WIDTH(8), .ADDR_W(3), .BYPASS(0)) dut2 (
        .clk(clk), .reset(reset2), .d(d2), .w_sel(w_sel2), .w_en(w_en2),
        .a_sel(a_sel2), .b_sel(b_sel2), .clr(clr2), .a(a2), .b(b2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Behavioural model: a sweep is equivalent to "all registers zero, file unusable for
    // 31 cycles"; the per-register order of the sweep is unobservable.
    logic [31:0] m [32];
    int          sweep_left = 31;

    always @(posedge clk) begin
        if (reset) begin
            sweep_left = 31;
            for (int i = 0; i < 32; i++) m[i] = '0;
        end else if (sweep_left > 0) begin
            sweep_left = sweep_left - 1;
        end else begin
            if (w_en && w_sel != 5'd31) m[w_sel] = d;
            if (clr) begin
                sweep_left = 31;
                for (int i = 0; i < 32; i++) m[i] = '0;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] sel, input bit byp);
        if (reset || sweep_left > 0) return '0;
        if (sel == 5'd31) return '0;
        if (byp && w_en && w_sel == sel) return d;
        return m[sel];
    endfunction

    // Compare process: both 32-bit instances checked every cycle.
    always @(negedge clk) begin
        chk("busy0", {31'd0, busy0}, {31'd0, (reset || sweep_left > 0)});
        chk("busy1", {31'd0, busy1}, {31'd0, (reset || sweep_left > 0)});
        chk("a0", a0, exp_rd(a_sel, 1'b0));
        chk("b0", b0, exp_rd(b_sel, 1'b0));
        chk("a1", a1, exp_rd(a_sel, 1'b1));
        chk("b1", b1, exp_rd(b_sel, 1'b1));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count sampled busy cycles of dut0, bounded; returns aligned just after a rising edge.
    task automatic count_busy0(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy0) break;
            n++;
        end
        step();
    endtask

    task automatic count_busy2(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy2) break;
            n++;
        end
        step();
    endtask

    int n;

    initial begin
        reset = 1'b1; d = '0; w_sel = '0; w_en = 1'b0; a_sel = '0; b_sel = '0; clr = 1'b0;
        reset2 = 1'b1; d2 = '0; w_sel2 = '0; w_en2 = 1'b0; a_sel2 = '0; b_sel2 = '0;
        clr2 = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("busy_in_reset", {31'd0, busy0}, 32'd1);
        step();

        // Power-on sweep
        reset = 1'b0;
        count_busy0(n);
        chk("sweep_len_reset", n, 32'd31);
        a_sel = 5'd0; b_sel = 5'd15;
        @(negedge clk);
        chk("rd0_after_sweep", a0, 32'h0);
        chk("rd15_after_sweep", b0, 32'h0);
        step();
        a_sel = 5'd30;
        @(negedge clk);
        chk("rd30_after_sweep", a0, 32'h0);
        step();

        // Basic write/read and zero register
        w_en = 1'b1; w_sel = 5'd3; d = 32'hDEADBEEF;
        step();
        w_sel = 5'd30; d = 32'h12345678;
        step();
        w_en = 1'b0; a_sel = 5'd3; b_sel = 5'd30;
        @(negedge clk);
        chk("rd_reg3", a0, 32'hDEADBEEF);
        chk("rd_reg30", b0, 32'h12345678);
        step();
        w_en = 1'b1; w_sel = 5'd31; d = 32'hFFFFFFFF;
        step();
        w_en = 1'b0; a_sel = 5'd31;
        @(negedge clk);
        chk("rd_reg31_zero", a0, 32'h0);
        step();

        // Bypass vs. no bypass
        w_en = 1'b1; w_sel = 5'd7; d = 32'h11111111;
        step();
        d = 32'hA5A5A5A5; a_sel = 5'd7; b_sel = 5'd7;
        @(negedge clk);
        chk("byp1_a", a1, 32'hA5A5A5A5);
        chk("byp1_b", b1, 32'hA5A5A5A5);
        chk("byp0_a_old", a0, 32'h11111111);
        chk("byp0_b_old", b0, 32'h11111111);
        step();
        w_en = 1'b0;
        @(negedge clk);
        chk("byp0_a_new", a0, 32'hA5A5A5A5);
        step();

        // clr sweep; write and clr during sweep are dropped
        w_en = 1'b1; w_sel = 5'd5; d = 32'h1;
        step();
        w_en = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0; w_en = 1'b1; w_sel = 5'd6; d = 32'h0000CAFE;
        step();
        w_en = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        count_busy0(n);
        chk("sweep_len_clr", n, 32'd29);
        a_sel = 5'd5; b_sel = 5'd6;
        @(negedge clk);
        chk("reg5_cleared", a0, 32'h0);
        chk("reg6_lost", b0, 32'h0);
        step();

        // Simultaneous write and clr: write lands, then sweep erases it
        w_en = 1'b1; w_sel = 5'd9; d = 32'h99; clr = 1'b1;
        step();
        w_en = 1'b0; clr = 1'b0;
        count_busy0(n);
        chk("sweep_len_clr_wr", n, 32'd31);
        a_sel = 5'd9;
        @(negedge clk);
        chk("reg9_erased", a0, 32'h0);
        step();

        // Reset 10 cycles into a clr sweep
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1;
        @(negedge clk);
        chk("busy_reset_mid", {31'd0, busy0}, 32'd1);
        step();
        step();
        reset = 1'b0;
        count_busy0(n);
        chk("sweep_len_reset_mid", n, 32'd31);

        // Mixed traffic, checked by the compare process
        for (int i = 0; i < 8; i++) begin
            w_en = 1'b1; w_sel = 5'(i * 4 + 1); d = 32'h1000_0000 + i * 32'h0101_0101;
            a_sel = 5'(i * 4 + 1); b_sel = 5'((i * 4 + 1 + 28) % 32);
            step();
        end
        w_en = 1'b0;
        a_sel = 5'd13; b_sel = 5'd29;
        @(negedge clk);
        chk("mix_reg13", a0, 32'h1303_0303);
        chk("mix_reg29", b0, 32'h1707_0707);
        step();

        // Small configuration
        reset2 = 1'b0;
        count_busy2(n);
        chk("sweep_len_small", n, 32'd7);
        a_sel2 = 3'd7; b_sel2 = 3'd0;
        @(negedge clk);
        chk("small_reg7", {24'd0, a2}, 32'h0);
        chk("small_reg0", {24'd0, b2}, 32'h0);
        step();
        w_en2 = 1'b1; w_sel2 = 3'd6; d2 = 8'h5A;
        step();
        w_sel2 = 3'd7; d2 = 8'hFF;
        step();
        w_en2 = 1'b0; a_sel2 = 3'd6; b_sel2 = 3'd7;
        @(negedge clk);
        chk("small_reg6", {24'd0, a2}, 32'h5A);
        chk("small_reg7_wr", {24'd0, b2}, 32'h0);
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
